// File: rtl/rf_dump_ctrl_if.sv
// rf_dump_ctrl_if: register dump beat stream.
//
// Handshake: a beat moves on a rising clk edge where dump_valid and
// dump_ready are both high. While dump_valid is high and dump_ready is low,
// the master holds dump_addr, dump_data and dump_last stable. The sink may
// raise dump_ready before dump_valid. dump_valid never depends
// combinationally on dump_ready.
//
// Signals:
//   dump_valid  master -> slave  beat available
//   dump_ready  slave  -> master sink accepts beat
//   dump_addr   master -> slave  register index of the beat
//   dump_data   master -> slave  register value of the beat
//   dump_last   master -> slave  beat is the last register of the range
interface rf_dump_ctrl_if;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_last;

    modport master (
        output dump_valid,
        output dump_addr,
        output dump_data,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_addr,
        input  dump_data,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: post-run register-file reader.
//
// Waits for the CPU's sticky finish flag and lets the pipeline drain for
// SETTLE_CYCLES. It then reads registers FIRST_REG..LAST_REG through the RF
// test port and streams each one out on the dump interface, adding every
// accepted beat into a checksum. A watchdog, enabled when TIMEOUT_CYCLES is
// nonzero, flags a program that never finishes.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   finish     CPU program-complete flag (level)
//   rdtaddr    RF test read address (always the internal index)
//   rdtdata    RF test read data, combinational from rdtaddr
//   dump       beat stream (master side)
//   checksum   running mod-2^32 sum of accepted beats
//   busy       high in SETTLE/FETCH/SEND
//   done       sticky, whole range dumped
//   timeout    sticky, watchdog expired
//   state_dbg  current FSM state encoding
module rf_dump_ctrl #(
    parameter int FIRST_REG      = 0,
    parameter int LAST_REG       = 31,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  finish,
    output logic [4:0]            rdtaddr,
    input  logic [31:0]           rdtdata,
    rf_dump_ctrl_if.master        dump,
    output logic [31:0]           checksum,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_FETCH   = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    localparam logic [4:0]  FIRST_IDX   = 5'(FIRST_REG);
    localparam logic [4:0]  LAST_IDX    = 5'(LAST_REG);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] WD_LIMIT    = 32'(TIMEOUT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  idx;
    logic [31:0] settle_cnt;
    logic [31:0] wd_cnt;
    logic        wd_expire;

    // Expiry is detected on the edge where the counter would reach the limit,
    // so TIMEOUT is entered exactly TIMEOUT_CYCLES edges after IDLE begins.
    assign wd_expire = (TIMEOUT_CYCLES != 0) && ((wd_cnt + 32'd1) == WD_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // finish takes priority over a simultaneous watchdog expiry
                if (finish) begin
                    state_nxt = S_SETTLE;
                end else if (wd_expire) begin
                    state_nxt = S_TIMEOUT;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_SEND;
            end
            S_SEND: begin
                if (dump.dump_ready) begin
                    state_nxt = (idx == LAST_IDX) ? S_DONE : S_FETCH;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx             <= FIRST_IDX;
            settle_cnt      <= '0;
            wd_cnt          <= '0;
            dump.dump_valid <= 1'b0;
            dump.dump_addr  <= '0;
            dump.dump_data  <= '0;
            dump.dump_last  <= 1'b0;
            checksum        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    settle_cnt <= '0;
                    if (!finish && (TIMEOUT_CYCLES != 0)) begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 32'd1;
                end
                S_FETCH: begin
                    dump.dump_data  <= rdtdata;
                    dump.dump_addr  <= idx;
                    dump.dump_last  <= (idx == LAST_IDX);
                    dump.dump_valid <= 1'b1;
                end
                S_SEND: begin
                    // dump_valid is always high here; outputs hold until accepted
                    if (dump.dump_ready) begin
                        checksum        <= checksum + dump.dump_data;
                        dump.dump_valid <= 1'b0;
                        dump.dump_last  <= 1'b0;
                        if (idx != LAST_IDX) begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rdtaddr   = idx;
    assign busy      = (state == S_SETTLE) || (state == S_FETCH) || (state == S_SEND);
    assign done      = (state == S_DONE);
    assign timeout   = (state == S_TIMEOUT);
    assign state_dbg = state;

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// tb_rf_dump_ctrl: self-checking bench for rf_dump_ctrl.
//
// Three instances share clk/rst and one register-file array:
//   dut_a  default parameters (full 0..31 dump, no watchdog)
//   dut_t  TIMEOUT_CYCLES=100, finish held low
//   dut_r  FIRST_REG=8, LAST_REG=15
// The dut_a scoreboard rebuilds its expected beat list from the register
// file whenever monitoring is disabled, then checks each accepted beat.
`timescale 1ns/1ps
module tb_rf_dump_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] rf [32];

    logic finish_a, finish_t, finish_r;

    rf_dump_ctrl_if a_if ();
    rf_dump_ctrl_if t_if ();
    rf_dump_ctrl_if r_if ();

    logic [4:0]  rdtaddr_a, rdtaddr_t, rdtaddr_r;
    logic [31:0] rdtdata_a, rdtdata_t, rdtdata_r;
    logic [31:0] checksum_a, checksum_t, checksum_r;
    logic        busy_a, busy_t, busy_r;
    logic        done_a, done_t, done_r;
    logic        timeout_a, timeout_t, timeout_r;
    logic [2:0]  state_a, state_t, state_r;

    assign rdtdata_a = rf[rdtaddr_a];
    assign rdtdata_t = rf[rdtaddr_t];
    assign rdtdata_r = rf[rdtaddr_r];

    rf_dump_ctrl dut_a (
        .clk(clk), .rst(rst), .finish(finish_a),
        .rdtaddr(rdtaddr_a), .rdtdata(rdtdata_a), .dump(a_if),
        .checksum(checksum_a), .busy(busy_a), .done(done_a),
        .timeout(timeout_a), .state_dbg(state_a)
    );

    rf_dump_ctrl #(.TIMEOUT_CYCLES(100)) dut_t (
        .clk(clk), .rst(rst), .finish(finish_t),
        .rdtaddr(rdtaddr_t), .rdtdata(rdtdata_t), .dump(t_if),
        .checksum(checksum_t), .busy(busy_t), .done(done_t),
        .timeout(timeout_t), .state_dbg(state_t)
    );

    rf_dump_ctrl #(.FIRST_REG(8), .LAST_REG(15)) dut_r (
        .clk(clk), .rst(rst), .finish(finish_r),
        .rdtaddr(rdtaddr_r), .rdtdata(rdtdata_r), .dump(r_if),
        .checksum(checksum_r), .busy(busy_r), .done(done_r),
        .timeout(timeout_r), .state_dbg(state_r)
    );

    assign t_if.dump_ready = 1'b1;
    assign r_if.dump_ready = 1'b1;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_sum(input int first, input int last);
        logic [31:0] s;
        s = '0;
        for (int i = first; i <= last; i++) s = s + rf[i];
        return s;
    endfunction

    // ---------------- scoreboard for dut_a ----------------
    // entry = {last, addr[4:0], data[31:0]}
    logic [37:0] exp_q [$];
    logic        mon_en = 1'b0;
    int          beats = 0;

    always @(negedge clk) begin
        logic [37:0] e;
        if (!mon_en) begin
            exp_q.delete();
            for (int i = 0; i <= 31; i++) exp_q.push_back({(i == 31), 5'(i), rf[i]});
            beats = 0;
        end else if (!rst && a_if.dump_valid && a_if.dump_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_beat_addr", {27'd0, a_if.dump_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("beat_addr", {27'd0, a_if.dump_addr}, {27'd0, e[36:32]});
                check_eq("beat_data", a_if.dump_data, e[31:0]);
                check_eq("beat_last", {31'd0, a_if.dump_last}, {31'd0, e[37]});
            end
            beats++;
        end
    end

    // ---------------- ready driver for dut_a ----------------
    // 0: always ready, 1: random, 2: stall 3 cycles on register 7
    int ready_mode = 0;
    int stall_cnt  = 0;

    always @(posedge clk) begin
        #1;
        if (ready_mode != 2) stall_cnt = 0;
        case (ready_mode)
            0: a_if.dump_ready = 1'b1;
            1: a_if.dump_ready = 1'($urandom_range(0, 1));
            default: begin
                if (a_if.dump_valid && a_if.dump_addr == 5'd7 && stall_cnt < 3) begin
                    stall_cnt++;
                    a_if.dump_ready = 1'b0;
                    check_eq("stall_addr", {27'd0, a_if.dump_addr}, 32'd7);
                    check_eq("stall_data", a_if.dump_data, 32'd7);
                    check_eq("stall_checksum", checksum_a, 32'h15);
                end else begin
                    a_if.dump_ready = 1'b1;
                end
            end
        endcase
    end

    logic t_valid_seen = 1'b0;
    always @(posedge clk) if (t_if.dump_valid) t_valid_seen <= 1'b1;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic rf_ramp();
        for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    endtask

    task automatic wait_done_a(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (done_a) break;
        end
        check_eq(tag, {31'd0, done_a}, 32'd1);
    endtask

    task automatic start_a();
        @(posedge clk); #1 finish_a = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] sum_exp;
        logic [31:0] sum_hold;
        rst = 1'b1;
        finish_a = 1'b0; finish_t = 1'b0; finish_r = 1'b0;
        rf_ramp();
        do_reset();

        // reset state
        check_eq("rst_valid", {31'd0, a_if.dump_valid}, 32'd0);
        check_eq("rst_addr", {27'd0, a_if.dump_addr}, 32'd0);
        check_eq("rst_data", a_if.dump_data, 32'd0);
        check_eq("rst_last", {31'd0, a_if.dump_last}, 32'd0);
        check_eq("rst_checksum", checksum_a, 32'd0);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_done", {31'd0, done_a}, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout_a}, 32'd0);
        check_eq("rst_rdtaddr_r", {27'd0, rdtaddr_r}, 32'd8);

        // watchdog: 100 edges in IDLE without finish
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 99)  check_eq("wd_before", {31'd0, timeout_t}, 32'd0);
            if (k == 100) check_eq("wd_expired", {31'd0, timeout_t}, 32'd1);
        end
        check_eq("wd_off_a", {31'd0, timeout_a}, 32'd0);
        finish_t = 1'b1;
        repeat (3) @(posedge clk);
        #1 finish_t = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("wd_sticky", {31'd0, timeout_t}, 32'd1);
        check_eq("wd_no_done", {31'd0, done_t}, 32'd0);
        check_eq("wd_no_busy", {31'd0, busy_t}, 32'd0);
        check_eq("wd_no_valid", {31'd0, t_valid_seen}, 32'd0);

        // full dump, always ready, first-valid latency
        rf_ramp(); ready_mode = 0; do_reset();
        @(posedge clk); #1 finish_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) check_eq("lat_busy", {31'd0, busy_a}, 32'd1);
            if (k == 5) check_eq("lat_not_yet", {31'd0, a_if.dump_valid}, 32'd0);
            if (k == 6) check_eq("lat_valid", {31'd0, a_if.dump_valid}, 32'd1);
        end
        wait_done_a("t1_done", 200);
        check_eq("t1_checksum", checksum_a, 32'h1F0);
        check_eq("t1_busy", {31'd0, busy_a}, 32'd0);
        check_eq("t1_beats", 32'(beats), 32'd32);
        check_eq("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // stall on register 7
        finish_a = 1'b0; rf_ramp(); ready_mode = 2; do_reset();
        start_a();
        wait_done_a("stall_done", 300);
        check_eq("stall_cycles", 32'(stall_cnt), 32'd3);
        check_eq("stall_final_checksum", checksum_a, 32'h1F0);
        check_eq("stall_beats", 32'(beats), 32'd32);
        ready_mode = 0;

        // asynchronous reset mid-dump at register 12
        finish_a = 1'b0; rf_ramp(); do_reset();
        start_a();
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (a_if.dump_valid && a_if.dump_addr == 5'd12) break;
        end
        check_eq("mid_reached12", {27'd0, a_if.dump_addr}, 32'd12);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", {31'd0, a_if.dump_valid}, 32'd0);
        check_eq("arst_addr", {27'd0, a_if.dump_addr}, 32'd0);
        check_eq("arst_data", a_if.dump_data, 32'd0);
        check_eq("arst_checksum", checksum_a, 32'd0);
        check_eq("arst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("arst_rdtaddr", {27'd0, rdtaddr_a}, 32'd0);
        do_reset();
        wait_done_a("restart_done", 200);
        check_eq("restart_checksum", checksum_a, 32'h1F0);
        check_eq("restart_beats", 32'(beats), 32'd32);

        // random data, random ready, finish dropped on beat 3, held after done
        for (int run = 0; run < 2; run++) begin
            finish_a = 1'b0;
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            sum_exp = model_sum(0, 31);
            ready_mode = 1; do_reset();
            start_a();
            for (int k = 0; k < 300; k++) begin
                @(posedge clk); #1;
                if (a_if.dump_valid && a_if.dump_addr == 5'd3) break;
            end
            check_eq("rnd_reached3", {27'd0, a_if.dump_addr}, 32'd3);
            finish_a = 1'b0;
            wait_done_a("rnd_done", 2000);
            check_eq("rnd_checksum", checksum_a, sum_exp);
            check_eq("rnd_beats", 32'(beats), 32'd32);
            check_eq("rnd_busy", {31'd0, busy_a}, 32'd0);
            sum_hold = checksum_a;
            finish_a = 1'b1;
            repeat (40) @(posedge clk);
            #1;
            check_eq("rnd_no_redump", 32'(beats), 32'd32);
            check_eq("rnd_checksum_hold", checksum_a, sum_hold);
            check_eq("rnd_done_sticky", {31'd0, done_a}, 32'd1);
        end
        ready_mode = 0;

        // sub-range dump on dut_r
        finish_a = 1'b0; rf_ramp(); do_reset();
        @(posedge clk); #1 finish_r = 1'b1;
        for (int b = 8; b <= 15; b++) begin
            for (int k = 0; k < 50; k++) begin
                @(posedge clk); #1;
                if (r_if.dump_valid) break;
            end
            check_eq("rng_addr", {27'd0, r_if.dump_addr}, 32'(b));
            check_eq("rng_data", r_if.dump_data, rf[b]);
            check_eq("rng_last", {31'd0, r_if.dump_last}, {31'd0, (b == 15)});
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done_r) break;
        end
        check_eq("rng_done", {31'd0, done_r}, 32'd1);
        check_eq("rng_checksum", checksum_r, 32'h5C);
        check_eq("rng_checksum_model", checksum_r, model_sum(8, 15));
        check_eq("rng_busy", {31'd0, busy_r}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
